// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode/funct constants, ALU-op and destination-select
// encodings, the ID/EX control bundle, and the immediate-extension helper.
package decode_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes with special decode (instr[5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [3:0] {
        ALU_RTYPE   = 4'd0,
        ALU_ADD     = 4'd1,
        ALU_ANDI    = 4'd2,
        ALU_XORI    = 4'd3,
        ALU_ORI     = 4'd4,
        ALU_BEQ     = 4'd5,
        ALU_BNE     = 4'd6,
        ALU_BLEZ    = 4'd7,
        ALU_BGTZ    = 4'd8,
        ALU_BGEZ    = 4'd9,
        ALU_SLTI    = 4'd10,
        ALU_LUI     = 4'd11,
        ALU_J       = 4'd12,
        ALU_JAL     = 4'd13,
        ALU_ILLEGAL = 4'd15
    } aluop_e;

    typedef enum logic [1:0] {
        DST_RT   = 2'd0,
        DST_RD   = 2'd1,
        DST_LINK = 2'd2
    } dst_sel_e;

    typedef struct packed {
        aluop_e   aluop;
        logic     alu_src;
        dst_sel_e dst_sel;
        logic     jmp;
        logic     branch;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     reg_write;
        logic     shift;
        logic     i_sign;
        logic     is_byte;
        logic     rs_is_src;
        logic     rt_is_src;
        logic     halt;
        logic     illegal;
    } ctrl_t;

    // Sign- or zero-extend a 16-bit immediate to 32 bits.
    function automatic logic [31:0] ext_imm16(input logic [15:0] imm, input logic sign);
        return sign ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// instr_decoder: purely combinational instruction word -> control bundle,
// register fields, resolved destination and extended immediate.
module instr_decoder
    import decode_pkg::*;
#(
    parameter logic [5:0] HALT_FUNCT = 6'b001100,
    parameter logic [4:0] LINK_REG   = 5'd31
) (
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  dst_o,
    output logic [4:0]  shamt_o,
    output logic [31:0] imm_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd;

    assign opcode  = instr_i[31:26];
    assign funct   = instr_i[5:0];
    assign rd      = instr_i[15:11];
    assign rs_o    = instr_i[25:21];
    assign rt_o    = instr_i[20:16];
    assign shamt_o = instr_i[10:6];

    // Opcode/funct to control bundle; every field starts from a zero default.
    always_comb begin
        ctrl_o         = '0;
        ctrl_o.aluop   = ALU_RTYPE;
        ctrl_o.dst_sel = DST_RT;
        case (opcode)
            OP_RTYPE: begin
                ctrl_o.dst_sel   = DST_RD;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.rs_is_src = 1'b1;
                ctrl_o.rt_is_src = 1'b1;
                if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA) begin
                    // Shifts take the amount from shamt, only rt is read
                    ctrl_o.shift     = 1'b1;
                    ctrl_o.rs_is_src = 1'b0;
                end else if (funct == FN_JR) begin
                    ctrl_o.jmp       = 1'b1;
                    ctrl_o.reg_write = 1'b0;
                    ctrl_o.rt_is_src = 1'b0;
                end else if (funct == HALT_FUNCT) begin
                    ctrl_o.halt      = 1'b1;
                    ctrl_o.reg_write = 1'b0;
                    ctrl_o.rs_is_src = 1'b0;
                    ctrl_o.rt_is_src = 1'b0;
                end
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl_o.aluop     = ALU_ADD;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.rs_is_src = 1'b1;
                ctrl_o.i_sign    = (opcode == OP_ADDI);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl_o.aluop     = (opcode == OP_ANDI) ? ALU_ANDI :
                                   (opcode == OP_ORI)  ? ALU_ORI  : ALU_XORI;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.rs_is_src = 1'b1;
            end
            OP_SLTI: begin
                ctrl_o.aluop     = ALU_SLTI;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.rs_is_src = 1'b1;
                ctrl_o.i_sign    = 1'b1;
            end
            OP_LUI: begin
                ctrl_o.aluop     = ALU_LUI;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OP_LW, OP_LB: begin
                ctrl_o.aluop      = ALU_ADD;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.i_sign     = 1'b1;
                ctrl_o.rs_is_src  = 1'b1;
                ctrl_o.is_byte    = (opcode == OP_LB);
            end
            OP_SW, OP_SB: begin
                ctrl_o.aluop     = ALU_ADD;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_sign    = 1'b1;
                ctrl_o.rs_is_src = 1'b1;
                ctrl_o.rt_is_src = 1'b1;
                ctrl_o.is_byte   = (opcode == OP_SB);
            end
            OP_BEQ, OP_BNE: begin
                ctrl_o.aluop     = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                ctrl_o.branch    = 1'b1;
                ctrl_o.i_sign    = 1'b1;
                ctrl_o.rs_is_src = 1'b1;
                ctrl_o.rt_is_src = 1'b1;
            end
            OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                ctrl_o.aluop     = (opcode == OP_BLEZ) ? ALU_BLEZ :
                                   (opcode == OP_BGTZ) ? ALU_BGTZ : ALU_BGEZ;
                ctrl_o.branch    = 1'b1;
                ctrl_o.i_sign    = 1'b1;
                ctrl_o.rs_is_src = 1'b1;
            end
            OP_J: begin
                ctrl_o.aluop = ALU_J;
                ctrl_o.jmp   = 1'b1;
            end
            OP_JAL: begin
                ctrl_o.aluop     = ALU_JAL;
                ctrl_o.jmp       = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dst_sel   = DST_LINK;
            end
            default: begin
                ctrl_o.aluop   = ALU_ILLEGAL;
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

    // Immediate formatting: LUI upper half, jump target, else 16-bit extension.
    always_comb begin
        if (opcode == OP_LUI) begin
            imm_o = {instr_i[15:0], 16'h0000};
        end else if (opcode == OP_J || opcode == OP_JAL) begin
            imm_o = {6'b000000, instr_i[25:0]};
        end else begin
            imm_o = ext_imm16(instr_i[15:0], ctrl_o.i_sign);
        end
    end

    // Destination register resolved from dst_sel.
    always_comb begin
        case (ctrl_o.dst_sel)
            DST_RD:   dst_o = rd;
            DST_LINK: dst_o = LINK_REG;
            default:  dst_o = rt_o;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered ID stage with valid/ready handshake, load-use
// bubble insertion, flush, and SYSCALL halt sequencing.
// Optional feature macro: DECODE_HAZARD_EN compiles in load-use detection;
// without it the hazard term is tied low and loads never cause a bubble.
module decode_stage
    import decode_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter logic [5:0] HALT_FUNCT = 6'b001100,
    parameter logic [4:0] LINK_REG   = 5'd31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              flush,
    output logic              id_valid,
    input  logic              ex_ready,
    output ctrl_t             id_ctrl,
    output logic [4:0]        id_rs,
    output logic [4:0]        id_rt,
    output logic [4:0]        id_dst,
    output logic [4:0]        id_shamt,
    output logic [31:0]       id_imm,
    output logic [ADDR_W-1:0] id_pc,
    output logic              hazard_stall,
    output logic              halted
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_HALT_PEND = 2'd1;
    localparam logic [1:0] ST_HALTED    = 2'd2;

    ctrl_t             dec_ctrl;
    logic [4:0]        dec_rs, dec_rt, dec_dst, dec_shamt;
    logic [31:0]       dec_imm;

    logic [1:0]        state_q, state_d;
    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, dst_q, dst_d, shamt_q, shamt_d;
    logic [31:0]       imm_q, imm_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    logic              hazard;
    logic              xfer;

    instr_decoder #(
        .HALT_FUNCT (HALT_FUNCT),
        .LINK_REG   (LINK_REG)
    ) u_dec (
        .instr_i (if_instr),
        .ctrl_o  (dec_ctrl),
        .rs_o    (dec_rs),
        .rt_o    (dec_rt),
        .dst_o   (dec_dst),
        .shamt_o (dec_shamt),
        .imm_o   (dec_imm)
    );

`ifdef DECODE_HAZARD_EN
    // A held load whose result the incoming instruction reads must drain first.
    always_comb begin
        hazard = valid_q && ctrl_q.mem_read && (dst_q != 5'd0) && if_valid &&
                 ((dec_ctrl.rs_is_src && (dec_rs == dst_q)) ||
                  (dec_ctrl.rt_is_src && (dec_rt == dst_q)));
    end
`else
    assign hazard = 1'b0;
`endif

    assign hazard_stall = hazard;
    assign if_ready     = (state_q == ST_RUN) && !flush && !hazard && (!valid_q || ex_ready);
    assign xfer         = if_valid && if_ready;

    // Output register next state: flush kills, transfer loads, EX consumption empties.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        dst_d   = dst_q;
        shamt_d = shamt_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            rs_d    = dec_rs;
            rt_d    = dec_rt;
            dst_d   = dec_dst;
            shamt_d = dec_shamt;
            imm_d   = dec_imm;
            pc_d    = if_pc;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end
    end

    // Halt sequencing; a flush while pending means the SYSCALL was speculative.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (xfer && dec_ctrl.halt) state_d = ST_HALT_PEND;
            end
            ST_HALT_PEND: begin
                if (flush)         state_d = ST_RUN;
                else if (ex_ready) state_d = ST_HALTED;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // State and ID/EX register update; reset discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dst_q   <= '0;
            shamt_q <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dst_q   <= dst_d;
            shamt_q <= shamt_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign id_valid = valid_q;
    assign id_ctrl  = ctrl_q;
    assign id_rs    = rs_q;
    assign id_rt    = rt_q;
    assign id_dst   = dst_q;
    assign id_shamt = shamt_q;
    assign id_imm   = imm_q;
    assign id_pc    = pc_q;
    assign halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage plus hand-written sequences
// for load-use, back-pressure, flush, halt and asynchronous reset.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        id_valid;
    logic        ex_ready;
    ctrl_t       id_ctrl;
    logic [4:0]  id_rs, id_rt, id_dst, id_shamt;
    logic [31:0] id_imm;
    logic [31:0] id_pc;
    logic        hazard_stall;
    logic        halted;

    decode_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .flush        (flush),
        .id_valid     (id_valid),
        .ex_ready     (ex_ready),
        .id_ctrl      (id_ctrl),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dst       (id_dst),
        .id_shamt     (id_shamt),
        .id_imm       (id_imm),
        .id_pc        (id_pc),
        .hazard_stall (hazard_stall),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [19:0] ctrl;   // {aluop, alu_src, dst_sel, jmp, branch, mem_read, mem_write,
                             //  mem_to_reg, reg_write, shift, i_sign, is_byte, rs_is_src,
                             //  rt_is_src, halt, illegal}
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [4:0]  shamt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    localparam logic [31:0] I_ADDI    = 32'h2008FFFF;  // addi $t0,$zero,-1
    localparam logic [31:0] I_ORI     = 32'h3409FFFF;  // ori  $t1,$zero,0xffff
    localparam logic [31:0] I_LUI     = 32'h3C0D1234;  // lui  $t5,0x1234
    localparam logic [31:0] I_LW      = 32'h8E080000;  // lw   $t0,0($s0)
    localparam logic [31:0] I_ADDDEP  = 32'h010A4820;  // add  $t1,$t0,$t2
    localparam logic [31:0] I_SYSCALL = 32'h0000000C;
    localparam logic [19:0] C_SYSCALL = {4'd0, 1'b0, 2'd1, 13'b0000000000010};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h2008FFFF, {4'd1,  1'b1, 2'd0, 13'b0000010101000}, 32'hFFFFFFFF, 5'd8,  5'd31};
        vecs[1]  = '{32'h3409FFFF, {4'd4,  1'b1, 2'd0, 13'b0000010001000}, 32'h0000FFFF, 5'd9,  5'd31};
        vecs[2]  = '{32'h252AFFFF, {4'd1,  1'b1, 2'd0, 13'b0000010001000}, 32'h0000FFFF, 5'd10, 5'd31};
        vecs[3]  = '{32'h012A5820, {4'd0,  1'b0, 2'd1, 13'b0000010001100}, 32'h00005820, 5'd11, 5'd0};
        vecs[4]  = '{32'h000B6100, {4'd0,  1'b0, 2'd1, 13'b0000011000100}, 32'h00006100, 5'd12, 5'd4};
        vecs[5]  = '{32'h3C0D1234, {4'd11, 1'b1, 2'd0, 13'b0000010000000}, 32'h12340000, 5'd13, 5'd8};
        vecs[6]  = '{32'h1109FFFC, {4'd5,  1'b0, 2'd0, 13'b0100000101100}, 32'hFFFFFFFC, 5'd9,  5'd31};
        vecs[7]  = '{32'hAFA80008, {4'd1,  1'b1, 2'd0, 13'b0001000101100}, 32'h00000008, 5'd8,  5'd0};
        vecs[8]  = '{32'h0C100040, {4'd13, 1'b0, 2'd2, 13'b1000010000000}, 32'h00100040, 5'd31, 5'd1};
        vecs[9]  = '{32'h03E00008, {4'd0,  1'b0, 2'd1, 13'b1000000001000}, 32'h00000008, 5'd0,  5'd0};
        vecs[10] = '{32'hFC000000, {4'd15, 1'b0, 2'd0, 13'b0000000000001}, 32'h00000000, 5'd0,  5'd0};
        vecs[11] = '{32'h820EFFFE, {4'd1,  1'b1, 2'd0, 13'b0010110111000}, 32'hFFFFFFFE, 5'd14, 5'd31};
        vecs[12] = '{32'h05010005, {4'd9,  1'b0, 2'd0, 13'b0100000101000}, 32'h00000005, 5'd1,  5'd0};
        vecs[13] = '{32'h39118000, {4'd3,  1'b1, 2'd0, 13'b0000010001000}, 32'h00008000, 5'd17, 5'd0};

        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst.id_ctrl",  {12'b0, id_ctrl},  32'd0);
        chk("rst.id_imm",   id_imm,            32'd0);
        chk("rst.id_dst",   {27'b0, id_dst},   32'd0);
        chk("rst.id_pc",    id_pc,             32'd0);
        chk("rst.halted",   {31'b0, halted},   32'd0);
        chk("rst.hazard",   {31'b0, hazard_stall}, 32'd0);
        rst_n = 1'b1;
        ex_ready = 1'b1;

        // Back-to-back decode table, one instruction per cycle
        for (int i = 0; i < NV; i++) begin
            if_valid = 1'b1;
            if_instr = vecs[i].instr;
            if_pc    = 32'h1000 + 32'(i * 4);
            #1;
            chk($sformatf("v%0d.if_ready", i), {31'b0, if_ready}, 32'd1);
            tick();
            chk($sformatf("v%0d.id_valid", i), {31'b0, id_valid}, 32'd1);
            chk($sformatf("v%0d.ctrl", i),     {12'b0, id_ctrl},  {12'b0, vecs[i].ctrl});
            chk($sformatf("v%0d.imm", i),      id_imm,            vecs[i].imm);
            chk($sformatf("v%0d.dst", i),      {27'b0, id_dst},   {27'b0, vecs[i].dst});
            chk($sformatf("v%0d.shamt", i),    {27'b0, id_shamt}, {27'b0, vecs[i].shamt});
            chk($sformatf("v%0d.pc", i),       id_pc,             32'h1000 + 32'(i * 4));
        end
        if_valid = 1'b0;
        tick();
        chk("drain.id_valid", {31'b0, id_valid}, 32'd0);

        // Load followed by a dependent ADD
        if_valid = 1'b1; if_instr = I_LW; if_pc = 32'h200;
        tick();
        chk("lu.lw_dst", {27'b0, id_dst}, 32'd8);
        if_instr = I_ADDDEP; if_pc = 32'h204;
        #1;
`ifdef DECODE_HAZARD_EN
        chk("lu.hazard_stall", {31'b0, hazard_stall}, 32'd1);
        chk("lu.if_ready",     {31'b0, if_ready},     32'd0);
        tick();
        chk("lu.bubble_valid", {31'b0, id_valid},     32'd0);
        chk("lu.hazard_clear", {31'b0, hazard_stall}, 32'd0);
        chk("lu.ready_again",  {31'b0, if_ready},     32'd1);
        tick();
`else
        chk("lu.hazard_stall", {31'b0, hazard_stall}, 32'd0);
        chk("lu.if_ready",     {31'b0, if_ready},     32'd1);
        tick();
`endif
        chk("lu.add_valid", {31'b0, id_valid}, 32'd1);
        chk("lu.add_dst",   {27'b0, id_dst},   32'd9);
        chk("lu.add_pc",    id_pc,             32'h204);
        if_valid = 1'b0;
        tick();

        // Back-pressure: EX stalls for three cycles
        if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h300;
        tick();
        ex_ready = 1'b0; if_instr = I_ORI; if_pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d.if_ready", k), {31'b0, if_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d.valid", k), {31'b0, id_valid}, 32'd1);
            chk($sformatf("bp%0d.imm", k),   id_imm,            32'hFFFFFFFF);
            chk($sformatf("bp%0d.dst", k),   {27'b0, id_dst},   32'd8);
            chk($sformatf("bp%0d.pc", k),    id_pc,             32'h300);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("bp.ori_imm", id_imm, 32'h0000FFFF);
        chk("bp.ori_pc",  id_pc,  32'h304);
        if_instr = I_LUI; if_pc = 32'h308;
        tick();
        chk("bp.lui_imm", id_imm, 32'h12340000);
        chk("bp.lui_pc",  id_pc,  32'h308);
        if_valid = 1'b0;
        tick();

        // Flush beats both acceptance and EX consumption
        if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h400;
        tick();
        flush = 1'b1; if_instr = I_ORI; if_pc = 32'h404;
        #1;
        chk("fl.if_ready", {31'b0, if_ready}, 32'd0);
        tick();
        chk("fl.id_valid", {31'b0, id_valid}, 32'd0);
        flush = 1'b0; if_valid = 1'b0;
        tick();

        // SYSCALL halt sequence
        if_valid = 1'b1; if_instr = I_SYSCALL; if_pc = 32'h500;
        tick();
        chk("halt.ctrl",     {12'b0, id_ctrl}, {12'b0, C_SYSCALL});
        chk("halt.pend_h",   {31'b0, halted},  32'd0);
        ex_ready = 1'b0; if_instr = I_ADDI;
        #1;
        chk("halt.pend_rdy", {31'b0, if_ready}, 32'd0);
        tick();
        chk("halt.pend_h2",  {31'b0, halted},   32'd0);
        chk("halt.pend_vld", {31'b0, id_valid}, 32'd1);
        ex_ready = 1'b1;
        tick();
        chk("halt.halted",   {31'b0, halted},   32'd1);
        chk("halt.valid",    {31'b0, id_valid}, 32'd0);
        chk("halt.if_ready", {31'b0, if_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("halt.flush_ign", {31'b0, halted},   32'd1);
        chk("halt.still_rdy", {31'b0, if_ready}, 32'd0);

        // Asynchronous reset from HALTED, no clock edge involved
        rst_n = 1'b0;
        #1;
        chk("arst.halted", {31'b0, halted},   32'd0);
        chk("arst.valid",  {31'b0, id_valid}, 32'd0);
        chk("arst.ctrl",   {12'b0, id_ctrl},  32'd0);
        chk("arst.pc",     id_pc,             32'd0);
        @(negedge clk);
        rst_n = 1'b1; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h600;
        #1;
        chk("arst.if_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("arst.next_vld", {31'b0, id_valid}, 32'd1);
        chk("arst.next_pc",  id_pc,             32'h600);

        // Flush while HALT_PEND returns to RUN
        if_instr = I_SYSCALL; if_pc = 32'h700;
        tick();
        ex_ready = 1'b0; flush = 1'b1; if_valid = 1'b0;
        tick();
        flush = 1'b0;
        chk("hpf.halted", {31'b0, halted},   32'd0);
        chk("hpf.valid",  {31'b0, id_valid}, 32'd0);
        if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h704; ex_ready = 1'b1;
        #1;
        chk("hpf.if_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("hpf.next_pc", id_pc,            32'h704);
        chk("hpf.halted2", {31'b0, halted},  32'd0);

        // Asynchronous reset while a valid instruction is held
        ex_ready = 1'b0; if_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst2.valid", {31'b0, id_valid}, 32'd0);
        chk("arst2.imm",   id_imm,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage for the MIPS-subset core, sitting between fetch (IF) and execute (EX). Each accepted instruction is decoded into a complete, latch-free control bundle plus extracted operands, held in an ID/EX output register under valid/ready flow control. Beyond a plain opcode decoder, the stage:
- detects load-use hazards and inserts a bubble;
- supports flush from a taken branch or jump;
- sequences SYSCALL halt through a small state machine.

## Interface
Parameters:
- ADDR_W, 32, PC width carried alongside the instruction
- HALT_FUNCT, 6'b001100, R-type funct code treated as SYSCALL/halt
- LINK_REG, 5'd31, destination register written by JAL

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_valid  in  1  IF presents an instruction
- if_ready  out  1  stage accepts the instruction this cycle
- if_instr  in  32  instruction word
- if_pc  in  ADDR_W  PC of if_instr
- flush  in  1  kill the held instruction and refuse input this cycle
- id_valid  out  1  output register holds a valid decoded instruction
- ex_ready  in  1  EX consumes the output register this cycle
- id_ctrl  out  ctrl_t  control bundle: aluop[3:0], alu_src, dst_sel[1:0], jmp, branch, mem_read, mem_write, mem_to_reg, reg_write, shift, i_sign, is_byte, rs_is_src, rt_is_src, halt, illegal
- id_rs, id_rt, id_dst, id_shamt  out  5 each  source registers, resolved destination, shift amount
- id_imm  out  32  extended immediate
- id_pc  out  ADDR_W  PC of the held instruction
- hazard_stall  out  1  load-use bubble being inserted this cycle
- halted  out  1  sticky; core has retired SYSCALL to EX

## Operation
- aluop encoding:
  - 0: R-type
  - 1: ADDI, ADDIU, LW, SW, LB, SB
  - 2 through 13: ANDI, XORI, ORI, BEQ, BNE, BLEZ, BGTZ, BGEZ, SLTI, LUI, J, JAL
  - 15: illegal
- Every ctrl_t field is assigned for every opcode/funct; there are no latches and no don't-cares on outputs.
- Unknown opcode:
  - illegal=1 and aluop=15
  - reg_write, mem_write, jmp and branch all 0
- dst_sel: 0=rt, 1=rd, 2=LINK_REG.
  - id_dst is resolved from dst_sel.
  - JAL: reg_write=1, dst_sel=2.
- Immediate extension:
  - i_sign=1 sign-extends imm16; i_sign=0 zero-extends. ADDIU, ANDI, ORI and XORI use i_sign=0.
  - LUI: id_imm = {imm16, 16'h0}.
  - J/JAL: id_imm = {6'b0, instr[25:0]}.
- R-type funct decoding:
  - SLL/SRL/SRA: shift=1, rt_is_src=1.
  - JR: jmp=1, rs_is_src=1, reg_write=0.
  - HALT_FUNCT: halt=1, reg_write=0.
- Transfer occurs when if_valid && if_ready; the output register loads the decoded result.
- The output register clears when ex_ready && !(new transfer).
- if_ready = (state==RUN) && !flush && !hazard && (!id_valid || ex_ready).
- Load-use hazard:
  - Condition: hazard = id_valid && id_ctrl.mem_read && id_dst!=0 && if_valid && ((rs_is_src(if) && rs==id_dst) || (rt_is_src(if) && rt==id_dst)).
  - While hazard is true the load drains to EX, id_valid drops, and exactly one bubble is inserted.
  - hazard_stall = hazard.
- Halt state machine:
  - RUN: accepting a halt instruction moves to HALT_PEND.
  - HALT_PEND: if_ready=0. When the SYSCALL transfers to EX (ex_ready), move to HALTED. flush in HALT_PEND returns to RUN, because the SYSCALL was speculative.
  - HALTED: halted=1 and if_ready=0 until reset. flush is ignored.
- flush:
  - id_valid goes to 0 next cycle.
  - flush takes priority over ex_ready and over acceptance.

## Timing
- Latency: 1 cycle from acceptance to id_valid. Throughput: 1 instruction per cycle with no hazard.
- id_* outputs are registered. if_ready and hazard_stall are combinational from inputs and state.
- While id_valid && !ex_ready, all id_* outputs hold stable.
- Reset values:
  - id_valid=0, id_ctrl=0 (aluop=0, illegal=0), all id_* fields=0
  - halted=0, state=RUN, hazard_stall=0
- Reset mid-operation discards the held instruction immediately and asynchronously.
- Simultaneous flush and hazard: flush wins; hazard_stall is still reported combinationally, but no state changes result from it.

## Configuration
- DECODE_HAZARD_EN defined: the load-use detection above is compiled in.
- Undefined: hazard is tied to 0 and hazard_stall=0. EX/MEM must then handle load-use itself, and back-to-back loads followed by their consumers issue without a bubble.

## Structure
- Package decode_pkg holds:
  - opcode and funct constants
  - aluop_e (4-bit enum) and dst_sel_e
  - ctrl_t packed struct
- One sub-module, instr_decoder: purely combinational instr→{ctrl_t, rs, rt, dst, shamt, imm}. decode_stage adds the handshake, hazard logic, state machine and registers.

## Test plan
- ADDI $t0,$zero,-1 (0x2008FFFF): id_imm=0xFFFFFFFF, aluop=1, dst_sel=0, reg_write=1 one cycle after acceptance. ORI with imm 0xFFFF gives id_imm=0x0000FFFF.
- LW $t0,0($s0) followed by ADD $t1,$t0,$t2 with ex_ready=1 (with DECODE_HAZARD_EN): hazard_stall=1 for one cycle, one bubble cycle with id_valid=0, then the ADD issues. Without the macro, there is no bubble.
- ex_ready=0 for 3 cycles with a valid held instruction: id_* outputs stable and if_ready=0; throughput resumes at 1 per cycle after release.
- SYSCALL accepted, then ex_ready=1: if_ready=0 from the next cycle and halted=1 after transfer. A repeat with flush asserted in HALT_PEND returns to RUN with halted=0.
- Opcode 0x3F: illegal=1, aluop=15, reg_write=0, mem_write=0. JAL: id_dst=31, reg_write=1, jmp=1.
- rst_n pulsed low while id_valid=1 and state=HALTED: all outputs are zero and state=RUN immediately, and the next instruction is accepted after release.
